// File: rtl/logic_cell_cfg_pkg.sv
// Shared definitions for the logic-cell configuration loader.
//   - cfg_state_t  : loader sequencer states
//   - field offsets of the per-cell configuration word
//   - MODE and output-mux select encodings
//   - cfg_word_illegal(): flags reserved/illegal field values in a word
package logic_cell_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } cfg_state_t;

  // Configuration word layout (LSB offsets, widths)
  localparam int LUT_LSB     = 0;
  localparam int LUT_W       = 16;
  localparam int MODE_LSB    = 16;
  localparam int QDI_MUX_LSB = 18;
  localparam int BQZ_MUX_LSB = 20;
  localparam int CQZ_MUX_LSB = 22;
  localparam int SEL_W       = 2;
  localparam int FIELD_W     = 24;

  typedef enum logic [1:0] {
    MODE_LUT_FF          = 2'd0,
    MODE_LUT_FF_SEPARATE = 2'd1,
    MODE_LUT_ADDER       = 2'd2,
    MODE_RESERVED        = 2'd3
  } cell_mode_t;

  typedef enum logic [1:0] {
    MUX_I0 = 2'd0,
    MUX_I1 = 2'd1,
    MUX_I2 = 2'd2,
    MUX_I3 = 2'd3
  } mux_sel_t;

  // A word is illegal when MODE is the reserved code or QDI_MUX selects I3.
  function automatic logic cfg_word_illegal(input logic [FIELD_W-1:0] word);
    logic [SEL_W-1:0] mode;
    logic [SEL_W-1:0] qdi;
    mode = word[MODE_LSB +: SEL_W];
    qdi  = word[QDI_MUX_LSB +: SEL_W];
    return (mode == MODE_RESERVED) || (qdi == MUX_I3);
  endfunction

endpackage

// File: rtl/logic_cell_cfg_loader_shift_reg.sv
// cfg_shift_reg: parallel-load, MSB-first serial shift register with a
// down-counting bit counter.
//   clk, rst_n  : clock, async active-low reset
//   load        : capture load_data, bit counter to W-1
//   load_data   : word to be shifted out
//   shift_en    : shift left one bit, decrement bit counter
//   sdo         : current MSB
//   last        : bit counter is at 0 (the bit on sdo is the final one)
module cfg_shift_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  output logic         sdo,
  output logic         last
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     sreg;
  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= load_data;
      bit_cnt <= CNT_W'(W - 1);
    end else if (shift_en) begin
      sreg <= {sreg[W-2:0], 1'b0};
      // Hold at zero rather than wrap; the sequencer leaves SHIFT on last.
      if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
    end
  end

  assign sdo  = sreg[W-1];
  assign last = (bit_cnt == '0);

endmodule

// File: rtl/logic_cell_cfg_loader.sv
// logic_cell_cfg_loader: accepts one configuration word per cell over a
// valid/ready handshake, shifts each word MSB-first into the column scan
// chain, then pulses CFG_LATCH so every cell switches configuration together.
//   QCK, QRT_N        : clock, async active-low reset
//   start, abort      : one-cycle session begin / cancel requests
//   cfg_valid/ready   : host word handshake, cfg_data the word
//   CFG_SEN, CFG_SDO  : chain shift enable and serial data
//   CFG_LATCH         : one-cycle parallel-load strobe
//   busy, done        : session in progress / one-cycle completion pulse
//   cfg_err           : sticky illegal-field flag, cleared by accepted start
//   state_dbg         : current sequencer state
//
// Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
// the host must hold cfg_valid and cfg_data stable until that edge, and
// cfg_data is ignored at all other times.
module logic_cell_cfg_loader
  import logic_cell_cfg_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int CFG_W     = 24
) (
  input  logic             QCK,
  input  logic             QRT_N,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             CFG_SEN,
  output logic             CFG_SDO,
  output logic             CFG_LATCH,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(NUM_CELLS + 1);
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(NUM_CELLS - 1);
  // Field check always sees at least a full 24-bit word (zero-extended).
  localparam int CHK_W = (CFG_W > FIELD_W) ? CFG_W : FIELD_W;

  cfg_state_t       state, next_state;
  logic [CNT_W-1:0] cell_cnt;
  logic             load, shift_en, start_ok, cell_inc;
  logic             sdo_raw, last_bit;
  logic [CHK_W-1:0] chk_word;
  logic             word_illegal;

  assign chk_word     = CHK_W'(cfg_data);
  assign word_illegal = cfg_word_illegal(chk_word[FIELD_W-1:0]);

  cfg_shift_reg #(.W(CFG_W)) u_shift_reg (
    .clk       (QCK),
    .rst_n     (QRT_N),
    .load      (load),
    .load_data (cfg_data),
    .shift_en  (shift_en),
    .sdo       (sdo_raw),
    .last      (last_bit)
  );

  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cfg_ready  = 1'b0;
    CFG_SEN    = 1'b0;
    CFG_LATCH  = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    start_ok   = 1'b0;
    cell_inc   = 1'b0;
    case (state)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          start_ok   = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          // ready is withheld so an aborted cycle never consumes a word
          next_state = IDLE;
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            load       = 1'b1;
            next_state = SHIFT;
          end
        end
      end
      SHIFT: begin
        CFG_SEN  = 1'b1;
        shift_en = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (last_bit) begin
          cell_inc   = 1'b1;
          next_state = (cell_cnt == LAST_CELL) ? LATCH : LOAD;
        end
      end
      LATCH: begin
        CFG_LATCH  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) begin
      cell_cnt <= '0;
      cfg_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (start_ok)      cell_cnt <= '0;
      else if (cell_inc) cell_cnt <= cell_cnt + CNT_W'(1);

      if (start_ok)                  cfg_err <= 1'b0;
      else if (load && word_illegal) cfg_err <= 1'b1;

      // done lands in the first IDLE cycle after the latch strobe
      done <= (state == LATCH);
    end
  end

  assign CFG_SDO   = CFG_SEN & sdo_raw;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_logic_cell_cfg_loader.sv
// Testbench for logic_cell_cfg_loader: an 8-cell and a 1-cell instance share
// the host bus; only the selected one is ever started. Serial output is
// checked bit-by-bit against a queue filled at each handshake.
module tb_logic_cell_cfg_loader;
  import logic_cell_cfg_pkg::*;

  localparam int W = 24;
  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT signals ----------------
  logic         start8 = 1'b0, start1 = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic ready8, sen8, sdo8, latch8, busy8, done8, err8;
  logic ready1, sen1, sdo1, latch1, busy1, done1, err1;
  logic [1:0] st8, st1;

  logic_cell_cfg_loader #(.NUM_CELLS(N), .CFG_W(W)) u_dut8 (
    .QCK(clk), .QRT_N(rst_n), .start(start8), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(ready8), .cfg_data(cfg_data),
    .CFG_SEN(sen8), .CFG_SDO(sdo8), .CFG_LATCH(latch8), .busy(busy8),
    .done(done8), .cfg_err(err8), .state_dbg(st8)
  );

  logic_cell_cfg_loader #(.NUM_CELLS(1), .CFG_W(W)) u_dut1 (
    .QCK(clk), .QRT_N(rst_n), .start(start1), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(ready1), .cfg_data(cfg_data),
    .CFG_SEN(sen1), .CFG_SDO(sdo1), .CFG_LATCH(latch1), .busy(busy1),
    .done(done1), .cfg_err(err1), .state_dbg(st1)
  );

  // ---------------- scoreboard state ----------------
  int   vectors = 0;
  int   miscompares = 0;
  logic sel = 1'b0;            // 0: 8-cell instance, 1: 1-cell instance
  logic [0:0] exp_q[$];        // expected serial bits, MSB-first
  int   sen_cnt, latch_cnt, done_cnt, first_sen_cyc, latch_cyc, done_cyc;
  logic err_at_done, busy_at_done;
  logic obs_bit;
  logic [0:0] exp_bit;
  int   hs_cyc;
  logic [W-1:0] words[N];
  int   gaps[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic cur_ready();
    return sel ? ready1 : ready8;
  endfunction

  function automatic logic cur_sen();
    return sel ? sen1 : sen8;
  endfunction

  function automatic logic [W-1:0] mk_word(input logic [1:0] cqz, input logic [1:0] bqz,
                                           input logic [1:0] qdi, input logic [1:0] mode,
                                           input logic [15:0] lut);
    return {cqz, bqz, qdi, mode, lut};
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (sen8 || sen1) begin
        obs_bit = sen8 ? sdo8 : sdo1;
        if (sen_cnt == 0) first_sen_cyc = cyc;
        sen_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL sdo_extra observed=%b expected=no_shift", obs_bit);
        end else begin
          exp_bit = exp_q.pop_front();
          check("sdo", obs_bit, exp_bit);
        end
      end
      if (latch8 || latch1) begin
        latch_cnt++;
        latch_cyc = cyc;
      end
      if (done8 || done1) begin
        done_cnt++;
        done_cyc     = cyc;
        err_at_done  = sel ? err1 : err8;
        busy_at_done = sel ? busy1 : busy8;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    sen_cnt = 0; latch_cnt = 0; done_cnt = 0;
    first_sen_cyc = -1; latch_cyc = -1; done_cyc = -1;
    err_at_done = 1'bx; busy_at_done = 1'bx;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic pulse_start(input logic with_abort, output int c0);
    c0 = cyc;
    if (sel) start1 = 1'b1; else start8 = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start1 = 1'b0; start8 = 1'b0; abort = 1'b0;
  endtask

  // Presents a word and holds valid until the handshake edge has passed.
  task automatic send_word(input logic [W-1:0] w);
    int t;
    t = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (!cur_ready() && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("handshake_timeout", 32'(t), 32'(0));
    end else begin
      hs_cyc = cyc;
      for (int b = W - 1; b >= 0; b--) exp_q.push_back(w[b]);
    end
    @(posedge clk); #1;
  endtask

  // Host idles: waits for ready, then stays silent for gap ready cycles.
  task automatic host_gap(input int gap);
    int t;
    t = 0;
    cfg_valid = 1'b0;
    cfg_data  = W'($urandom);
    while (!cur_ready() && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", 32'(t), 32'(0));
    for (int g = 0; g < gap; g++) begin
      check("bp_sen_low", 32'(cur_sen()), 32'(0));
      check("bp_ready_held", 32'(cur_ready()), 32'(1));
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("done_timeout", 32'(t), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_column(input logic use_gaps);
    for (int i = 0; i < N; i++) begin
      if (use_gaps) host_gap(gaps[i]);
      send_word(words[i]);
    end
    cfg_valid = 1'b0;
    wait_done();
  endtask

  // ---------------- directed sequence ----------------
  int c0;
  int gap_sum;

  initial begin
    clear_counts();
    for (int i = 0; i < N; i++)
      words[i] = mk_word(2'(i % 4), 2'((i + 1) % 4), 2'(i % 3), 2'(i % 3), 16'($urandom));

    // Reset and idle
    #2;
    check("rst_ready", 32'(ready8), 0);
    check("rst_sen", 32'(sen8), 0);
    check("rst_sdo", 32'(sdo8), 0);
    check("rst_latch", 32'(latch8), 0);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_err", 32'(err8), 0);
    check("rst_state", 32'(st8), 32'(IDLE));
    check("rst_ready1", 32'(ready1), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", 32'(ready8), 0);
    check("idle_busy", 32'(busy8), 0);

    // Single cell, word 24'h0A_BEEF
    sel = 1'b1;
    clear_counts();
    pulse_start(1'b0, c0);
    check("s1_busy", 32'(busy1), 1);
    send_word(24'h0A_BEEF);
    cfg_valid = 1'b0;
    check("s1_hs_cycle", 32'(hs_cyc - c0), 1);
    wait_done();
    check("s1_first_sen", 32'(first_sen_cyc - c0), 2);
    check("s1_sen_cnt", 32'(sen_cnt), 24);
    check("s1_latch_cycle", 32'(latch_cyc - c0), 26);
    check("s1_done_cycle", 32'(done_cyc - c0), 27);
    check("s1_latch_cnt", 32'(latch_cnt), 1);
    check("s1_busy_at_done", 32'(busy_at_done), 0);
    check("s1_q_empty", 32'(exp_q.size()), 0);

    // Full column, continuous valid
    sel = 1'b0;
    clear_counts();
    pulse_start(1'b0, c0);
    run_column(1'b0);
    check("col_sen_cnt", 32'(sen_cnt), 192);
    check("col_latch_cycle", 32'(latch_cyc - c0), 201);
    check("col_done_cycle", 32'(done_cyc - c0), 202);
    check("col_latch_cnt", 32'(latch_cnt), 1);
    check("col_done_cnt", 32'(done_cnt), 1);
    check("col_err", 32'(err_at_done), 0);
    check("col_busy_at_done", 32'(busy_at_done), 0);
    check("col_q_empty", 32'(exp_q.size()), 0);

    // Backpressure: gaps 0/3/7
    gap_sum = 0;
    for (int i = 0; i < N; i++) begin
      gaps[i] = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 3 : 7);
      gap_sum += gaps[i];
      words[i][15:0] = 16'($urandom);
    end
    clear_counts();
    pulse_start(1'b0, c0);
    run_column(1'b1);
    check("bp_sen_cnt", 32'(sen_cnt), 192);
    check("bp_latch_cycle", 32'(latch_cyc - c0), 32'(201 + gap_sum));
    check("bp_latch_cnt", 32'(latch_cnt), 1);
    check("bp_q_empty", 32'(exp_q.size()), 0);

    // Abort during the 5th bit of the 3rd word
    clear_counts();
    pulse_start(1'b0, c0);
    send_word(words[0]);
    send_word(words[1]);
    send_word(words[2]);
    cfg_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_sen_low", 32'(sen8), 0);
    check("abort_busy_low", 32'(busy8), 0);
    check("abort_state", 32'(st8), 32'(IDLE));
    check("abort_bits_left", 32'(exp_q.size()), 19);
    exp_q.delete();
    repeat (30) @(posedge clk);
    #1;
    check("abort_sen_cnt", 32'(sen_cnt), 53);
    check("abort_no_latch", 32'(latch_cnt), 0);
    check("abort_no_done", 32'(done_cnt), 0);

    // Illegal MODE in the second word; also proves restart after abort
    words[1][17:16] = 2'd3;
    clear_counts();
    pulse_start(1'b0, c0);
    check("ill_busy", 32'(busy8), 1);
    check("ill_err_clear", 32'(err8), 0);
    send_word(words[0]);
    check("ill_err_before", 32'(err8), 0);
    send_word(words[1]);
    check("ill_err_after_hs", 32'(err8), 1);
    for (int i = 2; i < N; i++) send_word(words[i]);
    cfg_valid = 1'b0;
    wait_done();
    check("ill_err_at_done", 32'(err_at_done), 1);
    check("ill_latch_cycle", 32'(latch_cyc - c0), 201);
    check("ill_q_empty", 32'(exp_q.size()), 0);
    check("ill_err_sticky", 32'(err8), 1);

    // Next start clears the flag; illegal QDI_MUX sets it again
    words[1][17:16] = 2'd1;
    words[5][19:18] = 2'd3;
    clear_counts();
    pulse_start(1'b0, c0);
    check("qdi_err_cleared", 32'(err8), 0);
    run_column(1'b0);
    check("qdi_err_at_done", 32'(err_at_done), 1);
    check("qdi_q_empty", 32'(exp_q.size()), 0);

    // start together with abort: session must not begin, flag untouched
    pulse_start(1'b1, c0);
    check("sa_busy", 32'(busy8), 0);
    check("sa_ready", 32'(ready8), 0);
    check("sa_err_kept", 32'(err8), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_cell_cfg_loader.md
# logic_cell_cfg_loader

Serial configuration sequencer for a column of `LOGIC_CELL` instances. It accepts one configuration word per cell from a host over a valid/ready handshake and shifts each word MSB-first into the column's configuration scan chain. Each word carries the cell's LUT truth table, MODE and output-mux selects. After the last cell it pulses a latch strobe, so all cells switch to the new configuration in the same cycle. It sits between the fabric configuration controller and the cell column.

## Interface
Parameters:
- `NUM_CELLS`, default 8: cells in the chain, ≥1.
- `CFG_W`, default 24: bits per cell word, ≥2.

Ports (clock and reset first):
- `QCK`  in  1  clock; all state is rising-edge.
- `QRT_N`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  one-cycle request to begin a session.
- `abort`  in  1  one-cycle request to cancel the session.
- `cfg_valid`  in  1  host word valid.
- `cfg_ready`  out  1  loader can accept a word.
- `cfg_data`  in  CFG_W  cell word; layout is in the package.
- `CFG_SEN`  out  1  chain shift enable.
- `CFG_SDO`  out  1  serial data to the chain.
- `CFG_LATCH`  out  1  one-cycle parallel-load strobe to all cells.
- `busy`  out  1  a session is in progress.
- `done`  out  1  one-cycle pulse when a session completes.
- `cfg_err`  out  1  sticky illegal-field flag; cleared by the next accepted `start`.

Reset values: all outputs 0, state IDLE, counters 0.

## Operation
- States:
  - IDLE: on `start`, go to LOAD with `busy`=1, `cell_cnt`=0 and `cfg_err` cleared. `start` outside IDLE is ignored.
  - LOAD: `cfg_ready`=1. On `cfg_valid && cfg_ready`, capture the word into the shift register, check its fields, set `bit_cnt`=CFG_W-1 and go to SHIFT.
  - SHIFT: `CFG_SEN`=1 and `CFG_SDO`=sreg[CFG_W-1]. Shift left each cycle and decrement `bit_cnt`. At `bit_cnt`==0, increment `cell_cnt`. If `cell_cnt` was NUM_CELLS-1 go to LATCH, otherwise go to LOAD.
  - LATCH: `CFG_LATCH`=1 for one cycle, then go to IDLE. On that transition `done` pulses and `busy` drops.
- `abort` in LOAD or SHIFT:
  - Next state is IDLE with `CFG_SEN`=0 and no latch or done.
  - `busy` falls on the next edge.
  - Cells keep their previously latched configuration.
- `abort` in LATCH is ignored: the latch completes.
- `abort` together with `start` in IDLE: `abort` wins and the session does not start.
- Field check on each accepted word:
  - A MODE value of 3 (reserved) sets `cfg_err`.
  - A QDI_MUX value of 3 sets `cfg_err`.
  - The word is still shifted unchanged.
- `cfg_valid` outside LOAD is not consumed, and the host must hold it.
- `cfg_data` is sampled only on handshake.

## Timing
- Handshake at edge T: `CFG_SEN` is high for cycles T+1 … T+CFG_W. `CFG_SDO` carries bit CFG_W-1 at T+1 and bit 0 at T+CFG_W.
- `cfg_ready` returns at T+CFG_W+1. Per-word cost is therefore CFG_W+1 cycles with `cfg_valid` held high.
- Last word: `CFG_LATCH` is high in the cycle after its final shift bit. `done` and `busy`=0 are in the following cycle.
- Full session with continuous valid, `start` at cycle 0:
  - first handshake at cycle 1;
  - `CFG_LATCH` at cycle 1+NUM_CELLS·(CFG_W+1);
  - `done` one cycle later.
- Reset mid-session: outputs drop asynchronously, `CFG_LATCH` is never produced, and the chain contents are undefined but not latched.
- `cell_cnt` width is $clog2(NUM_CELLS+1) and `bit_cnt` width is $clog2(CFG_W). Neither counter wraps: exit decisions use equality to the terminal value.

## Structure
- Package `logic_cell_cfg_pkg`:
  - state enum: IDLE, LOAD, SHIFT, LATCH;
  - field offsets: LUT [15:0], MODE [17:16], QDI_MUX [19:18], BQZ_MUX [21:20], CQZ_MUX [23:22];
  - MODE encodings: 0 LUT_FF, 1 LUT_FF_Separate, 2 LUT_ADDER, 3 reserved;
  - mux select encodings: I0 to I3.
- Sub-module `cfg_shift_reg`: parameterised width with load, shift-enable and serial MSB output. It holds the shift register and `bit_cnt` and signals last-bit. The top level holds the FSM, `cell_cnt` and the error logic.

## Test plan
- Reset and idle:
  - stimulus: QRT_N low, then high;
  - required: all outputs 0, and `cfg_ready`=0 until `start`.
- Single cell:
  - stimulus: NUM_CELLS=1, CFG_W=24, word 24'h0A_BEEF, `start` at cycle 0, valid at cycle 1;
  - required: SDO sequence at cycles 2…25 is the word MSB-first, `CFG_LATCH` at cycle 26, `done` at cycle 27.
- Full column:
  - stimulus: NUM_CELLS=8 with distinct words;
  - required: exactly 192 SEN-high cycles, `CFG_LATCH` at cycle 201, and a scoreboard match of the serial stream.
- Backpressure:
  - stimulus: host gaps of 0, 3 and 7 cycles between words;
  - required: no extra shift cycles, and SEN is low while the loader waits in LOAD.
- Abort:
  - stimulus: `abort` during the 5th bit of the 3rd word;
  - required: SEN low at the next cycle, no `CFG_LATCH` or `done`, and a new `start` is then accepted normally.
- Illegal fields:
  - stimulus: MODE=3 in word 2;
  - required: `cfg_err` high from the cycle after that handshake through `done`, the word is shifted unchanged, and `cfg_err` is cleared by the next `start`.
